// File: rtl/cr_gray_counter.sv
// cr_gray_counter
// Binary up/down counter with a registered Gray-code copy of the count.
// The Gray value is converted from the next binary value and captured in the
// same flop stage as the binary count, so both outputs come straight from
// flops and always agree.
//
// Next-state priority: rst, then ld, then en, then hold.
// wrap pulses for one cycle after a step that crossed all-ones <-> zero.

module cr_gray_counter #(
  parameter int p_width = 4,
  parameter int p_init  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic               ld,
  input  logic [p_width-1:0] d,
  output logic [p_width-1:0] b,
  output logic [p_width-1:0] g,
  output logic               wrap
);

  localparam logic [p_width-1:0] INIT_B   = p_width'(p_init);
  localparam logic [p_width-1:0] ALL_ONES = {p_width{1'b1}};
  localparam logic [p_width-1:0] ONE      = p_width'(1);

  function automatic logic [p_width-1:0] bin2gray(input logic [p_width-1:0] v);
    return v ^ (v >> 1);
  endfunction

  localparam logic [p_width-1:0] INIT_G = bin2gray(INIT_B);

  logic [p_width-1:0] step_b;
  logic [p_width-1:0] next_b;
  logic               step_wrap;
  logic               next_wrap;

  // Count step value and wrap detection; direction only matters when a step happens.
  always_comb begin
    step_b    = b;
    step_wrap = 1'b0;
    if (up) begin
      step_b    = b + ONE;
      step_wrap = (b == ALL_ONES);
    end else begin
      step_b    = b - ONE;
      step_wrap = (b == '0);
    end
  end

  // Non-reset next state: load beats count, count beats hold.
  always_comb begin
    next_b    = b;
    next_wrap = 1'b0;
    if (ld) begin
      next_b    = d;
      next_wrap = 1'b0;
    end else if (en) begin
      next_b    = step_b;
      next_wrap = step_wrap;
    end
  end

  // Single flop stage for binary, Gray and wrap; Gray comes from next_b, not from b.
  always_ff @(posedge clk) begin
    if (rst) begin
      b    <= INIT_B;
      g    <= INIT_G;
      wrap <= 1'b0;
    end else begin
      b    <= next_b;
      g    <= bin2gray(next_b);
      wrap <= next_wrap;
    end
  end

endmodule

// File: tb/tb_cr_gray_counter.sv
// Directed table vectors for 4-bit counters (init 0 and init 5) plus a
// random soak of a 6-bit counter against a small reference model.

module tb_cr_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 4-bit, init 0
  logic       r4, e4, u4, l4;
  logic [3:0] d4, b4, g4;
  logic       w4;
  // 4-bit, init 5
  logic       r5, e5, u5, l5;
  logic [3:0] d5, b5, g5;
  logic       w5;
  // 6-bit, init 37, soak
  logic       r6, e6, u6, l6;
  logic [5:0] d6, b6, g6;
  logic       w6;

  cr_gray_counter #(.p_width(4), .p_init(0)) dut4 (
    .clk(clk), .rst(r4), .en(e4), .up(u4), .ld(l4), .d(d4), .b(b4), .g(g4), .wrap(w4));
  cr_gray_counter #(.p_width(4), .p_init(5)) dut5 (
    .clk(clk), .rst(r5), .en(e5), .up(u5), .ld(l5), .d(d5), .b(b5), .g(g5), .wrap(w5));
  cr_gray_counter #(.p_width(6), .p_init(37)) dut6 (
    .clk(clk), .rst(r6), .en(e6), .up(u6), .ld(l6), .d(d6), .b(b6), .g(g6), .wrap(w6));

  typedef struct {
    string      name;
    logic       rst, ld, en, up;
    logic [3:0] d;
    logic [3:0] exp_b, exp_g;
    logic       exp_wrap;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string n, input logic rst, input logic ld, input logic en,
                     input logic up, input logic [3:0] d, input logic [3:0] eb,
                     input logic [3:0] eg, input logic ew);
    vec_t v;
    v.name = n; v.rst = rst; v.ld = ld; v.en = en; v.up = up; v.d = d;
    v.exp_b = eb; v.exp_g = eg; v.exp_wrap = ew;
    vq.push_back(v);
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] up_b[16] = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,0};
  logic [3:0] up_g[16] = '{1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0};

  logic [5:0] m_b;
  logic       m_w;
  logic [5:0] prev_g6;
  logic       was_step;

  initial begin
    logic [3:0] prev_g;
    r4 = 1; l4 = 0; e4 = 0; u4 = 0; d4 = '0;
    r5 = 1; l5 = 0; e5 = 0; u5 = 0; d5 = '0;
    r6 = 1; l6 = 0; e6 = 0; u6 = 0; d6 = '0;

    //   name          rst ld en up d   b   g   wrap
    add("reset",        1, 0, 1, 1, 9,  0,  0, 0);
    for (int i = 0; i < 16; i++)
      add("up_run",     0, 0, 1, 1, 0, up_b[i], up_g[i], (i == 15));
    add("down_wrap",    0, 0, 1, 0, 0, 15,  8, 1);
    add("down_next",    0, 0, 1, 0, 0, 14,  9, 0);
    add("load_over_en", 0, 1, 1, 1, 10, 10, 15, 0);
    add("after_load1",  0, 0, 1, 1, 0, 11, 14, 0);
    add("after_load2",  0, 0, 1, 1, 0, 12, 10, 0);
    add("up_13",        0, 0, 1, 1, 0, 13, 11, 0);
    add("up_14",        0, 0, 1, 1, 0, 14,  9, 0);
    add("up_15",        0, 0, 1, 1, 0, 15,  8, 0);
    add("rst_at_wrap",  1, 0, 1, 1, 0,  0,  0, 0);
    add("load_15",      0, 1, 0, 0, 15, 15, 8, 0);
    add("load_at_wrap", 0, 1, 1, 1, 3,  3,  2, 0);
    add("load_7",       0, 1, 0, 0, 7,  7,  4, 0);
    add("rev_up",       0, 0, 1, 1, 0,  8, 12, 0);
    add("rev_down",     0, 0, 1, 0, 0,  7,  4, 0);
    add("rev_down2",    0, 0, 1, 0, 0,  6,  5, 0);
    add("rev_up2",      0, 0, 1, 1, 0,  7,  4, 0);
    add("hold1",        0, 0, 0, 1, 0,  7,  4, 0);
    add("hold2",        0, 0, 0, 0, 0,  7,  4, 0);
    add("hold3",        0, 0, 0, 1, 0,  7,  4, 0);

    prev_g = '0;
    foreach (vq[i]) begin
      r4 = vq[i].rst; l4 = vq[i].ld; e4 = vq[i].en; u4 = vq[i].up; d4 = vq[i].d;
      tick();
      check({vq[i].name, ".b"},    b4, vq[i].exp_b);
      check({vq[i].name, ".g"},    g4, vq[i].exp_g);
      check({vq[i].name, ".wrap"}, w4, vq[i].exp_wrap);
      if (!vq[i].rst && !vq[i].ld && vq[i].en)
        check({vq[i].name, ".g_hamming"}, $countones(g4 ^ prev_g), 1);
      prev_g = g4;
    end
    r4 = 0; e4 = 0;

    // init 5: reset value, then reset in the cycle that would wrap
    r5 = 1; e5 = 1; u5 = 1;
    tick();
    check("init5_reset.b", b5, 5);
    check("init5_reset.g", g5, 7);
    check("init5_reset.wrap", w5, 0);
    r5 = 0; l5 = 1; d5 = 14; e5 = 0;
    tick();
    l5 = 0; e5 = 1; u5 = 1;
    tick();
    check("init5_at15.b", b5, 15);
    r5 = 1;
    tick();
    check("init5_rst_wrap.b", b5, 5);
    check("init5_rst_wrap.g", g5, 7);
    check("init5_rst_wrap.wrap", w5, 0);
    r5 = 0; e5 = 1; u5 = 0;
    tick();
    check("init5_down.b", b5, 4);
    check("init5_down.g", g5, 6);
    e5 = 0;

    // soak: 6-bit counter against a reference model
    r6 = 1;
    tick();
    m_b = 6'd37;
    check("soak_reset.b", b6, m_b);
    check("soak_reset.wrap", w6, 0);
    prev_g6 = g6;
    for (int c = 0; c < 10000; c++) begin
      r6 = ($urandom_range(0, 63) == 0);
      l6 = ($urandom_range(0, 15) == 0);
      e6 = ($urandom_range(0, 3) != 0);
      u6 = $urandom_range(0, 1) != 0;
      d6 = 6'($urandom_range(0, 63));
      was_step = 1'b0;
      m_w = 1'b0;
      if (r6) m_b = 6'd37;
      else if (l6) m_b = d6;
      else if (e6) begin
        was_step = 1'b1;
        if (u6) begin m_w = (m_b == 6'd63); m_b = m_b + 6'd1; end
        else    begin m_w = (m_b == 6'd0);  m_b = m_b - 6'd1; end
      end
      tick();
      check("soak.b", b6, m_b);
      check("soak.g", g6, m_b ^ (m_b >> 1));
      check("soak.wrap", w6, m_w);
      if (was_step) check("soak.g_hamming", $countones(g6 ^ prev_g6), 1);
      prev_g6 = g6;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
